paralelo_serial_tx: RTL and testbench
=====================================

Name: paralelo_serial_tx

Overview:
Transmit-side serializer that sits directly upstream of phy_rx and drives its datos_paralelo_serial input. It takes bytes over a valid/ready handshake and shifts them out MSB-first, one bit per clk_32f cycle. After reset it sends a fixed preamble of comma bytes (8'hBC) so the receiver can lock. Whenever no data byte is offered at a byte boundary, it inserts a comma as idle.

Parameters:
DATA_W, 8, byte width; fixed at 8 for this design.
COMMA, 8'hBC, sync/idle code word.
SYNC_COUNT, 4, number of comma bytes in the post-reset preamble.

Ports:
clk_32f  input  1  bit clock; the only clock.
rst_L  input  1  reset, asynchronous, active-low.
data_in  input  8  byte to transmit; sampled only on the handshake edge.
valid_in  input  1  data_in is valid.
ready_out  output  1  block accepts data_in at the next rising edge.
data_out  output  1  serial bit stream (connects to phy_rx datos_paralelo_serial).
sync_done  output  1  preamble finished; block is in RUN.
active_out  output  1  byte currently being shifted is payload, not comma.

Behaviour:
- Reset is asynchronous, active-low. While rst_L=0:
  - data_out=0, ready_out=0, sync_done=0, active_out=0.
  - bit_cnt=7, sync_cnt=0, state=SYNC, tx_byte=0.
- Assertion of rst_L=0 mid-byte abandons the partial byte immediately. After release the preamble restarts from zero.
- bit_cnt (3 bits) tracks the bit on data_out.
  - Boundary edge = a rising edge with bit_cnt==7.
  - On a boundary edge: tx_byte <= selected byte, data_out <= selected[7], bit_cnt <= 0.
  - On any other edge: data_out <= tx_byte[6-bit_cnt], bit_cnt <= bit_cnt+1.
  - Each byte therefore occupies exactly 8 cycles, MSB first. There are no gaps between bytes.
- Because reset leaves bit_cnt=7, the first edge after reset release is a boundary edge.
- State SYNC:
  - Every boundary edge selects COMMA, sets active_out=0 and increments sync_cnt.
  - The boundary edge that loads comma number SYNC_COUNT also moves state to RUN and sets sync_done=1.
  - sync_cnt width is clog2(SYNC_COUNT+1). It saturates and does not wrap.
- State RUN:
  - ready_out = (state==RUN) && (bit_cnt==7). It is combinational from registers, so it is high for one cycle in every 8.
  - Handshake: a boundary edge with valid_in=1 loads data_in and sets active_out=1.
  - A boundary edge with valid_in=0 loads COMMA and sets active_out=0 (idle insertion).
  - valid_in while ready_out=0 is ignored and nothing is latched. The source must hold data_in/valid_in until it sees ready_out.
- Latency: a byte accepted at edge E gives its MSB on data_out after E and its LSB after E+7. The next acceptance is at E+8.
- data_in equal to COMMA is transmitted unchanged with active_out=1. No escaping is done. Upper layers must not send 8'hBC as payload.
- There is no path from RUN back to SYNC except reset.
- Timing with edge 1 as the first edge after reset release:
  - Commas load at edges 1, 9, 17 and 25. Edge 25 enters RUN.
  - ready_out is first high in the cycle between edges 32 and 33.
  - The first payload byte loads at edge 33.

Decomposition:
- Package phy_pkg holds:
  - localparams COMMA=8'hBC and SYNC_COUNT=4;
  - the state encoding (SYNC=1'b0, RUN=1'b1);
  - DATA_W.
- phy_rx imports the same package, so both ends agree on the code word and preamble length.
- Sub-module: none required. A single module holding the FSM, bit counter and shift register is natural.

Test Plan:
1. Reset, valid_in=0 for 80 cycles -> data_out = 10111100 repeated ten times; sync_done rises after edge 25; active_out stays 0; ready_out pulses at cycles 32, 40, 48...
2. After sync, hold valid_in=1 with data_in=8'hF2 then 8'h15 -> after edge 33 data_out = 11110010, then 00010101 with no gap; ready_out high only at bit_cnt==7; active_out=1 for both bytes.
3. Send 8'hDD, 8'h45, 8'hAA, drop valid for one boundary, then 8'h13 -> bytes DD, 45, AA, BC (active_out=0), 13 serialized MSB-first, back to back.
4. Assert rst_L=0 at the 4th bit of a payload byte -> all outputs go to 0 in the same time step; after release, four BC bytes are sent before ready_out reasserts.
5. Raise valid_in=1 at bit_cnt==3 while ready_out=0 -> no load mid-byte; the byte is taken at the next boundary and the current byte is undisturbed.
6. Loopback: connect data_out to phy_rx with the conductual and synth models, send DD, 45, AA, 13 repeated -> both phy_rx models assert their valid outputs and present identical data_out_0..3 equal to the sent sequence.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY constants: code word, preamble length and serializer state encoding.
// The receiver imports the same package so both ends agree on framing.
package phy_pkg;

    localparam int          DATA_W     = 8;
    localparam logic [7:0]  COMMA      = 8'hBC;
    localparam int          SYNC_COUNT = 4;
    localparam int          SYNC_CNT_W = $clog2(SYNC_COUNT + 1);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: comma preamble after reset, then MSB-first payload
// over a valid/ready handshake with comma insertion whenever no byte is offered.
//
// state | meaning
// SYNC  | sending the post-reset comma preamble; data_in is never accepted
// RUN   | preamble done; each byte boundary takes data_in or inserts an idle comma
module paralelo_serial_tx
    import phy_pkg::*;
(
    input  logic              clk_32f,
    input  logic              rst_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              sync_done,
    output logic              active_out
);

    localparam logic [2:0]            LAST_BIT     = 3'd7;
    localparam logic [SYNC_CNT_W-1:0] SYNC_LAST    = SYNC_CNT_W'(SYNC_COUNT - 1);
    localparam logic [SYNC_CNT_W-1:0] SYNC_SAT     = SYNC_CNT_W'(SYNC_COUNT);

    tx_state_e               state_q;
    logic [2:0]              bit_cnt_q;
    logic [SYNC_CNT_W-1:0]   sync_cnt_q;
    logic [DATA_W-1:0]       tx_byte_q;
    logic                    data_out_q;
    logic                    active_q;
    logic                    sync_done_q;

    logic                    boundary;
    logic                    take_payload;
    logic [DATA_W-1:0]       sel_byte_d;
    logic [2:0]              shift_idx;

    assign boundary     = (bit_cnt_q == LAST_BIT);
    assign take_payload = (state_q == RUN) && valid_in;
    assign shift_idx    = 3'd6 - bit_cnt_q;

    always_comb begin
        sel_byte_d = COMMA;
        if (take_payload) begin
            sel_byte_d = data_in;
        end
    end

    always_ff @(posedge clk_32f or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= SYNC;
            bit_cnt_q   <= LAST_BIT;
            sync_cnt_q  <= '0;
            tx_byte_q   <= '0;
            data_out_q  <= 1'b0;
            active_q    <= 1'b0;
            sync_done_q <= 1'b0;
        end else if (boundary) begin
            bit_cnt_q  <= 3'd0;
            tx_byte_q  <= sel_byte_d;
            data_out_q <= sel_byte_d[DATA_W-1];
            active_q   <= take_payload;
            if (state_q == SYNC) begin
                if (sync_cnt_q != SYNC_SAT) begin
                    sync_cnt_q <= sync_cnt_q + 1'b1;
                end
                // This edge loads the final preamble comma.
                if (sync_cnt_q == SYNC_LAST) begin
                    state_q     <= RUN;
                    sync_done_q <= 1'b1;
                end
            end
        end else begin
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            data_out_q <= tx_byte_q[shift_idx];
        end
    end

    assign ready_out  = (state_q == RUN) && boundary;
    assign data_out   = data_out_q;
    assign sync_done  = sync_done_q;
    assign active_out = active_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: preamble, payload, idle insertion,
// mid-byte reset and early valid, each bit checked against hand-computed bytes.
module tb_paralelo_serial_tx;

    logic       clk_32f;
    logic       rst_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       sync_done;
    logic       active_out;

    int errors = 0;
    int checks = 0;

    paralelo_serial_tx dut (
        .clk_32f    (clk_32f),
        .rst_L      (rst_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .sync_done  (sync_done),
        .active_out (active_out)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Eight edges of one byte. After edge i the line carries b[7-i]; ready is
    // expected only after the eighth edge and only when rdy_end is set.
    // If set_at >= 0, valid_in/data_in are raised right after edge set_at.
    task automatic check_byte(input logic [7:0] b, input logic act, input logic syn,
                              input logic rdy_end, input int set_at,
                              input logic [7:0] set_data, input string tag);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_32f);
            #1;
            chk({tag, "_data"}, data_out, b[7-i]);
            chk({tag, "_act"}, active_out, act);
            chk({tag, "_sync"}, sync_done, syn);
            chk({tag, "_rdy"}, ready_out, rdy_end && (i == 7));
            if (i == set_at) begin
                valid_in = 1'b1;
                data_in  = set_data;
            end
        end
    endtask

    task automatic check_preamble(input string tag);
        check_byte(8'hBC, 1'b0, 1'b0, 1'b0, -1, 8'h00, {tag, "_c1"});
        check_byte(8'hBC, 1'b0, 1'b0, 1'b0, -1, 8'h00, {tag, "_c2"});
        check_byte(8'hBC, 1'b0, 1'b0, 1'b0, -1, 8'h00, {tag, "_c3"});
        check_byte(8'hBC, 1'b0, 1'b1, 1'b1, -1, 8'h00, {tag, "_c4"});
    endtask

    logic [7:0] f0_byte;

    initial begin
        rst_L    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        f0_byte  = 8'hF0;
        #23;
        chk("rst_data", data_out, 1'b0);
        chk("rst_rdy", ready_out, 1'b0);
        chk("rst_sync", sync_done, 1'b0);
        chk("rst_act", active_out, 1'b0);
        @(negedge clk_32f);
        rst_L = 1'b1;

        // Preamble plus idle commas with no valid offered: ten BC bytes.
        check_preamble("pre");
        for (int k = 0; k < 6; k++) begin
            check_byte(8'hBC, 1'b0, 1'b1, 1'b1, -1, 8'h00, "idle");
        end

        // Back-to-back payload.
        valid_in = 1'b1;
        data_in  = 8'hF2;
        check_byte(8'hF2, 1'b1, 1'b1, 1'b1, -1, 8'h00, "pF2");
        data_in = 8'h15;
        check_byte(8'h15, 1'b1, 1'b1, 1'b1, -1, 8'h00, "p15");
        data_in = 8'hDD;
        check_byte(8'hDD, 1'b1, 1'b1, 1'b1, -1, 8'h00, "pDD");
        data_in = 8'h45;
        check_byte(8'h45, 1'b1, 1'b1, 1'b1, -1, 8'h00, "p45");
        data_in = 8'hAA;
        check_byte(8'hAA, 1'b1, 1'b1, 1'b1, -1, 8'h00, "pAA");
        valid_in = 1'b0;
        data_in  = 8'h77;
        check_byte(8'hBC, 1'b0, 1'b1, 1'b1, -1, 8'h00, "gap");
        valid_in = 1'b1;
        data_in  = 8'h13;
        check_byte(8'h13, 1'b1, 1'b1, 1'b1, -1, 8'h00, "p13");
        valid_in = 1'b0;

        // Valid raised mid-byte must wait for the next boundary.
        check_byte(8'hBC, 1'b0, 1'b1, 1'b1, 3, 8'h5A, "early");
        check_byte(8'h5A, 1'b1, 1'b1, 1'b1, -1, 8'h00, "p5A");
        valid_in = 1'b0;

        // Comma as payload goes out unchanged, marked active.
        valid_in = 1'b1;
        data_in  = 8'hBC;
        check_byte(8'hBC, 1'b1, 1'b1, 1'b1, -1, 8'h00, "pBC");

        // Reset during the fourth bit of a payload byte.
        data_in = f0_byte;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_32f);
            #1;
            chk("mid_data", data_out, f0_byte[7-i]);
            chk("mid_act", active_out, 1'b1);
        end
        valid_in = 1'b0;
        rst_L    = 1'b0;
        #1;
        chk("arst_data", data_out, 1'b0);
        chk("arst_rdy", ready_out, 1'b0);
        chk("arst_sync", sync_done, 1'b0);
        chk("arst_act", active_out, 1'b0);
        @(negedge clk_32f);
        rst_L = 1'b1;
        check_preamble("re");
        valid_in = 1'b1;
        data_in  = 8'h81;
        check_byte(8'h81, 1'b1, 1'b1, 1'b1, -1, 8'h00, "p81");
        valid_in = 1'b0;
        check_byte(8'hBC, 1'b0, 1'b1, 1'b1, -1, 8'h00, "tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
